// File: rtl/vga_timing_pkg.sv
// Shared video timing definitions: detector FSM states, default counter width and
// the panel timing constants used by both the timing generator and the detector.
package vga_timing_pkg;

  localparam int VTD_CW_DEFAULT = 12;

  localparam int VACTIVE = 272;
  localparam int VFRONT  = 4;
  localparam int VSYNC   = 10;
  localparam int VBACK   = 2;
  localparam int VTOTAL  = 288;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } vtd_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one timing input, normalises it to active-high and flags the
// inactive-to-active transition between consecutive registered samples.
module sync_edge_detect #(
  parameter bit ACT = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic level_o,
  output logic edge_o
);

  logic r_level;
  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_level <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_level <= (sig_i == ACT);
      r_prev  <= r_level;
    end
  end

  assign level_o = r_level;
  assign edge_o  = r_level & ~r_prev;

endmodule

// File: rtl/video_timing_detector.sv
// Recovers pixel/line position, line and frame totals and a lock flag from hsync/vsync.
// Define VTD_DE_EN to add de_i, hactive_o/vactive_o and include them in the lock match.
module video_timing_detector
  import vga_timing_pkg::*;
#(
  parameter int CW          = VTD_CW_DEFAULT,
  parameter bit HSYNC_ACT   = 1'b0,
  parameter bit VSYNC_ACT   = 1'b0,
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_FRAMES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          hsync_i,
  input  logic          vsync_i,
`ifdef VTD_DE_EN
  input  logic          de_i,
  output logic [CW-1:0] hactive_o,
  output logic [CW-1:0] vactive_o,
`endif
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          frame_o,
  output logic [CW-1:0] htotal_o,
  output logic [CW-1:0] vtotal_o,
  output logic          locked_o
);

  localparam logic [CW-1:0] MAX    = '1;
  localparam logic [3:0]    LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [3:0]    MISS_N = 4'(MISS_FRAMES);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX) ? v : v + 1'b1;
  endfunction

  logic w_hs_level, w_hs_edge, w_vs_level, w_vs_edge;

  sync_edge_detect #(.ACT(HSYNC_ACT)) u_hs (
    .clk_i(clk_i), .rst_i(rst_i), .sig_i(hsync_i), .level_o(w_hs_level), .edge_o(w_hs_edge)
  );
  sync_edge_detect #(.ACT(VSYNC_ACT)) u_vs (
    .clk_i(clk_i), .rst_i(rst_i), .sig_i(vsync_i), .level_o(w_vs_level), .edge_o(w_vs_edge)
  );

  logic [CW-1:0] r_px, r_ln, r_htot_line, r_htot, r_vtot, r_x, r_y;
  logic          r_vs_d, r_frame;
  logic [CW-1:0] w_htot_new, w_ln_h;
  logic          w_px_sat, w_ln_sat;

  // hsync is applied before vsync, so a coincident edge closes the line first.
  assign w_htot_new = w_hs_edge ? sat_inc(r_px) : r_htot_line;
  assign w_ln_h     = w_hs_edge ? sat_inc(r_ln) : r_ln;
  assign w_px_sat   = (r_px == MAX);
  assign w_ln_sat   = (r_ln == MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_px        <= '0;
      r_ln        <= '0;
      r_htot_line <= '0;
      r_htot      <= '0;
      r_vtot      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_vs_d      <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      r_px <= w_hs_edge ? '0 : sat_inc(r_px);
      r_ln <= w_vs_edge ? '0 : w_ln_h;
      if (w_hs_edge) r_htot_line <= w_htot_new;
      if (w_vs_edge) begin
        r_htot <= w_htot_new;
        r_vtot <= w_ln_h;
      end
      r_vs_d  <= w_vs_edge;
      r_frame <= r_vs_d;
      r_x     <= r_px;
      r_y     <= r_ln;
    end
  end

`ifdef VTD_DE_EN
  logic          w_de_level, w_de_edge, w_line_de;
  logic [CW-1:0] r_hcnt, r_hact_line, r_vcnt, r_hact, r_vact;
  logic [CW-1:0] w_hact_new, w_vact_new;

  sync_edge_detect #(.ACT(1'b1)) u_de (
    .clk_i(clk_i), .rst_i(rst_i), .sig_i(de_i), .level_o(w_de_level), .edge_o(w_de_edge)
  );

  // hactive reports the last line that carried DE, so blanking lines do not zero it.
  assign w_line_de  = (r_hcnt != '0);
  assign w_hact_new = (w_hs_edge && w_line_de) ? r_hcnt : r_hact_line;
  assign w_vact_new = (w_hs_edge && w_line_de) ? sat_inc(r_vcnt) : r_vcnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hcnt      <= '0;
      r_hact_line <= '0;
      r_vcnt      <= '0;
      r_hact      <= '0;
      r_vact      <= '0;
    end else begin
      if (w_hs_edge) begin
        r_hcnt <= {{(CW-1){1'b0}}, w_de_level};
        if (w_line_de) r_hact_line <= r_hcnt;
      end else if (w_de_level) begin
        r_hcnt <= sat_inc(r_hcnt);
      end
      r_vcnt <= w_vs_edge ? '0 : w_vact_new;
      if (w_vs_edge) begin
        r_hact <= w_hact_new;
        r_vact <= w_vact_new;
      end
    end
  end

  assign hactive_o = r_hact;
  assign vactive_o = r_vact;

  logic w_unused;
  assign w_unused = ^{w_hs_level, w_vs_level, w_de_edge};
`else
  logic w_unused;
  assign w_unused = ^{w_hs_level, w_vs_level};
`endif

  vtd_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_ref_h, r_ref_v, w_ref_h_nxt, w_ref_v_nxt;
  logic [3:0]    r_match, r_miss, w_match_nxt, w_miss_nxt;
  logic          w_same;

`ifdef VTD_DE_EN
  logic [CW-1:0] r_ref_ha, r_ref_va, w_ref_ha_nxt, w_ref_va_nxt;
  assign w_same = (w_htot_new == r_ref_h) && (w_ln_h == r_ref_v) &&
                  (w_hact_new == r_ref_ha) && (w_vact_new == r_ref_va);
`else
  assign w_same = (w_htot_new == r_ref_h) && (w_ln_h == r_ref_v);
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ref_h_nxt = r_ref_h;
    w_ref_v_nxt = r_ref_v;
    w_match_nxt = r_match;
    w_miss_nxt  = r_miss;
`ifdef VTD_DE_EN
    w_ref_ha_nxt = r_ref_ha;
    w_ref_va_nxt = r_ref_va;
`endif
    if (w_px_sat || w_ln_sat) begin
      w_state_nxt = SEARCH;
      w_match_nxt = '0;
      w_miss_nxt  = '0;
    end else if (w_vs_edge) begin
      unique case (r_state)
        SEARCH: begin
          w_ref_h_nxt = w_htot_new;
          w_ref_v_nxt = w_ln_h;
`ifdef VTD_DE_EN
          w_ref_ha_nxt = w_hact_new;
          w_ref_va_nxt = w_vact_new;
`endif
          w_match_nxt = '0;
          w_miss_nxt  = '0;
          w_state_nxt = CHECK;
        end
        CHECK: begin
          if (w_same) begin
            w_match_nxt = r_match + 4'd1;
            if (r_match + 4'd1 == LOCK_N) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_match_nxt = '0;
            w_ref_h_nxt = w_htot_new;
            w_ref_v_nxt = w_ln_h;
`ifdef VTD_DE_EN
            w_ref_ha_nxt = w_hact_new;
            w_ref_va_nxt = w_vact_new;
`endif
          end
        end
        LOCKED: begin
          if (w_same) begin
            w_miss_nxt = '0;
          end else if (r_miss + 4'd1 == MISS_N) begin
            w_miss_nxt  = '0;
            w_match_nxt = '0;
            w_state_nxt = SEARCH;
          end else begin
            w_miss_nxt = r_miss + 4'd1;
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= SEARCH;
      r_ref_h <= '0;
      r_ref_v <= '0;
      r_match <= '0;
      r_miss  <= '0;
`ifdef VTD_DE_EN
      r_ref_ha <= '0;
      r_ref_va <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ref_h <= w_ref_h_nxt;
      r_ref_v <= w_ref_v_nxt;
      r_match <= w_match_nxt;
      r_miss  <= w_miss_nxt;
`ifdef VTD_DE_EN
      r_ref_ha <= w_ref_ha_nxt;
      r_ref_va <= w_ref_va_nxt;
`endif
    end
  end

  assign x_o      = r_x;
  assign y_o      = r_y;
  assign frame_o  = r_frame;
  assign htotal_o = r_htot;
  assign vtotal_o = r_vtot;
  assign locked_o = (r_state == LOCKED);

endmodule
